key_debounce: RTL and testbench

KEY_DEBOUNCE -- requirements
Module: key_debounce

---
 rtl/key_debounce.sv | 147 ++++++++++++++
 tb/tb_key_debounce.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/key_debounce.sv
// Four-channel pushbutton debouncer with press/release edge pulses and
// per-key auto-repeat. Each key runs through its own synchronizer bit,
// stability counter and repeat FSM; the channels share nothing but the clock.
module key_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned REPEAT_DELAY    = 25000000,
    parameter int unsigned REPEAT_RATE     = 5000000
) (
    input  logic       iCLK_50,
    input  logic       iRST,
    input  logic [3:0] iKEY,
    output logic [3:0] oKEY_STATE,
    output logic [3:0] oPRESS,
    output logic [3:0] oRELEASE,
    output logic [3:0] oREPEAT
);

    localparam int unsigned DbW    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned RepMax = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned RepW   = $clog2(RepMax + 1);

    localparam logic [DbW-1:0]  DbLast    = DbW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RepW-1:0] DelayLast = RepW'(REPEAT_DELAY - 1);
    localparam logic [RepW-1:0] RateLast  = RepW'(REPEAT_RATE - 1);

    typedef enum logic [1:0] {
        StIdle,
        StDelay,
        StRepeat
    } rep_state_e;

    logic [3:0] sync1_q;
    logic [3:0] sync2_q;
    logic [3:0] pressed_s;

    // Two-flop synchronizer; resets to the released (high) level.
    always_ff @(posedge iCLK_50 or posedge iRST) begin
        if (iRST) begin
            sync1_q <= 4'hF;
            sync2_q <= 4'hF;
        end else begin
            sync1_q <= iKEY;
            sync2_q <= sync1_q;
        end
    end

    // Keys are active-low on the pins; everything downstream is active-high.
    assign pressed_s = ~sync2_q;

    for (genvar g = 0; g < 4; g++) begin : g_ch
        logic [DbW-1:0]  db_cnt_q, db_cnt_d;
        logic            level_q, level_d;
        logic            press_q, press_d;
        logic            release_q, release_d;
        logic            accept_press, accept_release;
        rep_state_e      state_q, state_d;
        logic [RepW-1:0] rep_cnt_q, rep_cnt_d;
        logic            repeat_q, repeat_d;

        // Stability counter: runs while the input disagrees with the accepted level.
        always_comb begin
            db_cnt_d       = '0;
            level_d        = level_q;
            accept_press   = 1'b0;
            accept_release = 1'b0;
            if (pressed_s[g] != level_q) begin
                if (db_cnt_q == DbLast) begin
                    level_d        = ~level_q;
                    accept_press   = ~level_q;
                    accept_release = level_q;
                end else begin
                    db_cnt_d = db_cnt_q + 1'b1;
                end
            end
            press_d   = accept_press;
            release_d = accept_release;
        end

        // Repeat FSM; release wins over any repeat pulse due in the same cycle.
        always_comb begin
            state_d   = state_q;
            rep_cnt_d = rep_cnt_q;
            repeat_d  = 1'b0;
            if (accept_release) begin
                state_d   = StIdle;
                rep_cnt_d = '0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (accept_press) begin
                            state_d   = StDelay;
                            rep_cnt_d = '0;
                        end
                    end
                    StDelay: begin
                        if (rep_cnt_q == DelayLast) begin
                            state_d   = StRepeat;
                            rep_cnt_d = '0;
                            repeat_d  = 1'b1;
                        end else begin
                            rep_cnt_d = rep_cnt_q + 1'b1;
                        end
                    end
                    StRepeat: begin
                        if (rep_cnt_q == RateLast) begin
                            rep_cnt_d = '0;
                            repeat_d  = 1'b1;
                        end else begin
                            rep_cnt_d = rep_cnt_q + 1'b1;
                        end
                    end
                    default: begin
                        state_d   = StIdle;
                        rep_cnt_d = '0;
                    end
                endcase
            end
        end

        // Channel state and registered output pulses.
        always_ff @(posedge iCLK_50 or posedge iRST) begin
            if (iRST) begin
                db_cnt_q  <= '0;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                state_q   <= StIdle;
                rep_cnt_q <= '0;
                repeat_q  <= 1'b0;
            end else begin
                db_cnt_q  <= db_cnt_d;
                level_q   <= level_d;
                press_q   <= press_d;
                release_q <= release_d;
                state_q   <= state_d;
                rep_cnt_q <= rep_cnt_d;
                repeat_q  <= repeat_d;
            end
        end

        assign oKEY_STATE[g] = level_q;
        assign oPRESS[g]     = press_q;
        assign oRELEASE[g]   = release_q;
        assign oREPEAT[g]    = repeat_q;
    end

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce with short debounce/repeat parameters.
module tb_key_debounce;

    localparam int unsigned Db = 4;
    localparam int unsigned Rd = 10;
    localparam int unsigned Rr = 5;

    logic       clk;
    logic       rst;
    logic [3:0] key;
    logic [3:0] st, pr, rl, rp;

    int n_cmp  = 0;
    int n_fail = 0;

    key_debounce #(
        .DEBOUNCE_CYCLES(Db),
        .REPEAT_DELAY   (Rd),
        .REPEAT_RATE    (Rr)
    ) dut (
        .iCLK_50   (clk),
        .iRST      (rst),
        .iKEY      (key),
        .oKEY_STATE(st),
        .oPRESS    (pr),
        .oRELEASE  (rl),
        .oREPEAT   (rp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] key;
        logic [3:0] st;
        logic [3:0] pr;
        logic [3:0] rl;
        logic [3:0] rp;
    } vec_t;

    vec_t tbl [0:28];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_all(input string name, input logic [3:0] e_st, input logic [3:0] e_pr,
                           input logic [3:0] e_rl, input logic [3:0] e_rp);
        chk({name, " state"}, st, e_st);
        chk({name, " press"}, pr, e_pr);
        chk({name, " release"}, rl, e_rl);
        chk({name, " repeat"}, rp, e_rp);
    endtask

    // Drive keys in mask low and wait (bounded) for the press pulse.
    task automatic wait_press(input logic [3:0] mask, input string name);
        int n;
        n   = 0;
        key = ~mask;
        do begin
            tick();
            n++;
        end while (pr == 4'h0 && n < 20);
        chk_int({name, " press latency"}, n, Db + 2);
        chk({name, " press value"}, pr, mask);
        chk({name, " press state"}, st, mask);
        chk({name, " press repeat"}, rp, 4'h0);
    endtask

    // Press mask, release with first sampling edge at offset rel_at after the
    // press cycle, and check every cycle up to offset last against the model.
    task automatic run_press(input logic [3:0] mask, input int rel_at, input int last,
                             input string name);
        int rel_off;
        logic [3:0] e_st, e_rl, e_rp;
        wait_press(mask, name);
        rel_off = rel_at + Db + 1;
        for (int off = 1; off <= last; off++) begin
            if (off == rel_at) key = 4'hF;
            tick();
            e_st = (off < rel_off) ? mask : 4'h0;
            e_rl = (off == rel_off) ? mask : 4'h0;
            e_rp = (off < rel_off && off >= Rd && ((off - Rd) % Rr) == 0) ? mask : 4'h0;
            chk_all($sformatf("%s +%0d", name, off), e_st, 4'h0, e_rl, e_rp);
        end
    endtask

    initial begin
        // Clean press on key 3, then release
        tbl[0] = '{4'hF, 4'h0, 4'h0, 4'h0, 4'h0};
        for (int i = 1; i <= 5; i++) tbl[i] = '{4'h7, 4'h0, 4'h0, 4'h0, 4'h0};
        tbl[6] = '{4'h7, 4'h8, 4'h8, 4'h0, 4'h0};
        tbl[7] = '{4'h7, 4'h8, 4'h0, 4'h0, 4'h0};
        tbl[8] = '{4'h7, 4'h8, 4'h0, 4'h0, 4'h0};
        for (int i = 9; i <= 13; i++) tbl[i] = '{4'hF, 4'h8, 4'h0, 4'h0, 4'h0};
        tbl[14] = '{4'hF, 4'h0, 4'h0, 4'h8, 4'h0};
        tbl[15] = '{4'hF, 4'h0, 4'h0, 4'h0, 4'h0};
        // Bounce on key 1: low 3, high 2, low 2, then high
        for (int i = 16; i <= 18; i++) tbl[i] = '{4'hD, 4'h0, 4'h0, 4'h0, 4'h0};
        tbl[19] = '{4'hF, 4'h0, 4'h0, 4'h0, 4'h0};
        tbl[20] = '{4'hF, 4'h0, 4'h0, 4'h0, 4'h0};
        tbl[21] = '{4'hD, 4'h0, 4'h0, 4'h0, 4'h0};
        tbl[22] = '{4'hD, 4'h0, 4'h0, 4'h0, 4'h0};
        for (int i = 23; i <= 28; i++) tbl[i] = '{4'hF, 4'h0, 4'h0, 4'h0, 4'h0};

        rst = 1'b1;
        key = 4'hF;
        tick();
        tick();
        chk_all("reset", 4'h0, 4'h0, 4'h0, 4'h0);
        rst = 1'b0;

        for (int i = 0; i <= 28; i++) begin
            key = tbl[i].key;
            tick();
            chk_all($sformatf("vec%0d", i), tbl[i].st, tbl[i].pr, tbl[i].rl, tbl[i].rp);
        end

        // Auto-repeat on key 0: held 40 cycles past the press
        run_press(4'h1, 41, 55, "autorep");
        // Release accepted exactly when a repeat is due (+20)
        run_press(4'h4, 15, 30, "collide");
        // Re-press shows the FSM restarted from idle: first repeat at +10 again
        run_press(4'h4, 16, 25, "repress");
        // All four keys at once
        run_press(4'hF, 23, 35, "simul");

        // Reset three cycles into the delay phase with key 0 held
        wait_press(4'h1, "rstpre");
        for (int i = 0; i < 3; i++) tick();
        rst = 1'b1;
        #1;
        chk_all("rst immediate", 4'h0, 4'h0, 4'h0, 4'h0);
        tick();
        tick();
        chk_all("rst held", 4'h0, 4'h0, 4'h0, 4'h0);
        begin
            int n;
            n   = 0;
            rst = 1'b0;
            do begin
                tick();
                n++;
            end while (pr == 4'h0 && n < 20);
            chk_int("rst repress latency", n, Db + 2);
            chk("rst repress value", pr, 4'h1);
        end
        for (int off = 1; off <= 12; off++) begin
            if (off == 1) key = 4'hF;
            tick();
            chk_all($sformatf("rstrel +%0d", off), (off < 6) ? 4'h1 : 4'h0, 4'h0,
                    (off == 6) ? 4'h1 : 4'h0, 4'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
